// File: rtl/wb_openram_rw_arbiter.sv
// Two-master Wishbone front end for the OpenRAM RW port 0.
// Each access is arbitrated, sequenced through issue/wait/ack, and given one registered ack.
module wb_openram_rw_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int PRIORITY_A   = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_dat_i,
  input  logic [ADDR_WIDTH+1:0] wbs_a_adr_i,
  output logic                  wbs_a_ack_o,
  output logic [31:0]           wbs_a_dat_o,
  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_dat_i,
  input  logic [ADDR_WIDTH+1:0] wbs_b_adr_i,
  output logic                  wbs_b_ack_o,
  output logic [31:0]           wbs_b_dat_o,
  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;     // 1 = B
  logic                  last_q, last_d;       // 1 = B was granted last
  logic                  we_q, we_d;
  logic                  csb_q, csb_d, web_q, web_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [31:0]           dat_a_q, dat_a_d, dat_b_q, dat_b_d;
  logic                  req_a, req_b, pick_b, owner_cyc;
  logic                  unused_adr_bits;

  assign req_a     = wbs_a_stb_i & wbs_a_cyc_i;
  assign req_b     = wbs_b_stb_i & wbs_b_cyc_i;
  assign owner_cyc = owner_q ? wbs_b_cyc_i : wbs_a_cyc_i;
  assign unused_adr_bits = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) pick_b = (PRIORITY_A == 0) ? ~last_q : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    dat_a_d = dat_a_q;
    dat_b_d = dat_b_q;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_d = S_ISSUE;
          owner_d = pick_b;
          last_d  = pick_b;
          we_d    = pick_b ? wbs_b_we_i : wbs_a_we_i;
          csb_d   = 1'b0;
          web_d   = ~we_d;
          wmask_d = pick_b ? wbs_b_sel_i : wbs_a_sel_i;
          addr_d  = pick_b ? wbs_b_adr_i[ADDR_WIDTH+1:2] : wbs_a_adr_i[ADDR_WIDTH+1:2];
          din_d   = pick_b ? wbs_b_dat_i : wbs_a_dat_i;
        end
      end
      S_ISSUE: begin
        if (!owner_cyc) begin
          state_d = S_IDLE;
        end else if (we_q) begin
          state_d = S_ACK;
          ack_a_d = ~owner_q;
          ack_b_d = owner_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(READ_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (!owner_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          ack_a_d = ~owner_q;
          ack_b_d = owner_q;
          if (owner_q) dat_b_d = ram_dout0;
          else         dat_a_d = ram_dout0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 4'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      dat_a_q <= 32'd0;
      dat_b_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      dat_a_q <= dat_a_d;
      dat_b_q <= dat_b_d;
    end
  end

  assign ram_clk0    = wb_clk_i;
  assign ram_csb0    = csb_q;
  assign ram_web0    = web_q;
  assign ram_wmask0  = wmask_q;
  assign ram_addr0   = addr_q;
  assign ram_din0    = din_q;
  assign wbs_a_ack_o = ack_a_q;
  assign wbs_b_ack_o = ack_b_q;
  assign wbs_a_dat_o = dat_a_q;
  assign wbs_b_dat_o = dat_b_q;
  assign busy_o      = (state_q != S_IDLE);
  assign grant_o     = busy_o ? {owner_q, ~owner_q} : 2'b00;

endmodule

// File: tb/tb_wb_openram_rw_arbiter.sv
// Scoreboard bench for wb_openram_rw_arbiter: randomized two-master traffic against a
// word-level memory model, plus directed reset, abort and tie cases.
module tb_wb_openram_rw_arbiter;
  localparam int AW = 8;
  localparam int RL = 1;
  localparam int PRIO_A = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_stb = 0, a_cyc = 0, a_we = 0, b_stb = 0, b_cyc = 0, b_we = 0;
  logic [3:0] a_sel = 0, b_sel = 0;
  logic [31:0] a_dat = 0, b_dat = 0;
  logic [AW+1:0] a_adr = 0, b_adr = 0;
  logic a_ack, b_ack;
  logic [31:0] a_dout, b_dout;
  logic ram_clk0, ram_csb0, ram_web0;
  logic [3:0] ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [31:0] ram_din0;
  logic [31:0] ram_dout0 = 32'd0;
  logic [1:0] grant_o;
  logic busy_o;

  always #5 clk = ~clk;

  wb_openram_rw_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .PRIORITY_A(PRIO_A)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbs_a_stb_i(a_stb), .wbs_a_cyc_i(a_cyc), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
    .wbs_a_dat_i(a_dat), .wbs_a_adr_i(a_adr), .wbs_a_ack_o(a_ack), .wbs_a_dat_o(a_dout),
    .wbs_b_stb_i(b_stb), .wbs_b_cyc_i(b_cyc), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
    .wbs_b_dat_i(b_dat), .wbs_b_adr_i(b_adr), .wbs_b_ack_o(b_ack), .wbs_b_dat_o(b_dout),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
    .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0),
    .grant_o(grant_o), .busy_o(busy_o));

  // RAM macro stand-in: samples on the rising edge, read data held until the next read.
  logic [31:0] mem [256];
  always @(posedge ram_clk0) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int i = 0; i < 4; i++)
          if (ram_wmask0[i]) mem[ram_addr0][8*i +: 8] <= ram_din0[8*i +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  typedef struct packed { logic b; logic we; logic [31:0] dat; } exp_t;
  exp_t sbq[$];
  logic [31:0] ref_mem [256];
  bit last_b = 1'b1;
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_x(input bit m, input bit we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.b = m;
    e.we = we;
    if (we) begin
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      e.dat = 32'd0;
    end else begin
      e.dat = ref_mem[a];
    end
    sbq.push_back(e);
  endtask

  // Monitor: pops one expectation per ack and tracks what each dat_o must hold.
  logic [31:0] mda = 32'd0, mdb = 32'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mda = 32'd0;
      mdb = 32'd0;
    end else if (a_ack || b_ack) begin
      exp_t e;
      check("ack_onehot", 32'(a_ack & b_ack), 32'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: ack_a=%0b ack_b=%0b with nothing outstanding at %0t",
                 a_ack, b_ack, $time);
      end else begin
        e = sbq.pop_front();
        check("ack_owner", 32'(b_ack), 32'(e.b));
        if (!e.we) begin
          if (e.b) mdb = e.dat;
          else     mda = e.dat;
        end
        check("dat_a", a_dout, mda);
        check("dat_b", b_dout, mdb);
      end
    end
  end

  task automatic drop_a(); a_stb = 0; a_cyc = 0; endtask
  task automatic drop_b(); b_stb = 0; b_cyc = 0; endtask

  task automatic round(input bit ra, input bit rb, input bit wa, input bit wbb,
                       input logic [7:0] aa, input logic [7:0] ab,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic [3:0] sa, input logic [3:0] sb);
    bit fb, a_done, b_done;
    int lat;
    @(posedge clk); #1;
    fb = (ra && rb) ? ((PRIO_A != 0) ? 1'b0 : !last_b) : rb;
    if (fb) begin
      expect_x(1'b1, wbb, ab, db, sb);
      if (ra) expect_x(1'b0, wa, aa, da, sa);
    end else begin
      expect_x(1'b0, wa, aa, da, sa);
      if (rb) expect_x(1'b1, wbb, ab, db, sb);
    end
    last_b = (ra && rb) ? !fb : fb;
    lat = (fb ? wbb : wa) ? 2 : 2 + RL;
    a_stb = ra; a_cyc = ra; a_we = wa; a_sel = sa; a_dat = da;
    a_adr = {aa, 2'($urandom_range(0, 3))};
    b_stb = rb; b_cyc = rb; b_we = wbb; b_sel = sb; b_dat = db;
    b_adr = {ab, 2'($urandom_range(0, 3))};
    a_done = !ra;
    b_done = !rb;
    for (int c = 1; c <= 60 && !(a_done && b_done); c++) begin
      @(posedge clk); #1;
      if (c == 1) check("grant", 32'(grant_o), fb ? 32'd2 : 32'd1);
      if (!a_done && a_ack) begin
        if (!fb) check("latency_a", 32'(c), 32'(lat));
        drop_a();
        a_done = 1;
      end
      if (!b_done && b_ack) begin
        if (fb) check("latency_b", 32'(c), 32'(lat));
        drop_b();
        b_done = 1;
      end
    end
    if (!(a_done && b_done)) begin
      check("round_timeout", 32'd0, 32'd1);
      drop_a();
      drop_b();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset values, then idle after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_csb0", 32'(ram_csb0), 32'd1);
    check("rst_web0", 32'(ram_web0), 32'd1);
    check("rst_wmask0", 32'(ram_wmask0), 32'd0);
    check("rst_addr0", 32'(ram_addr0), 32'd0);
    check("rst_din0", ram_din0, 32'd0);
    check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    check("rst_dat_a", a_dout, 32'd0);
    check("rst_dat_b", b_dout, 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_csb0", 32'(ram_csb0), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);

    // A write 0x010 <- DEADBEEF, RAM-side timing
    expect_x(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    last_b = 1'b0;
    a_stb = 1; a_cyc = 1; a_we = 1; a_sel = 4'hF; a_dat = 32'hDEADBEEF; a_adr = 10'h010;
    @(posedge clk); #1;
    check("wr_csb0", 32'(ram_csb0), 32'd0);
    check("wr_web0", 32'(ram_web0), 32'd0);
    check("wr_addr0", 32'(ram_addr0), 32'h04);
    check("wr_din0", ram_din0, 32'hDEADBEEF);
    check("wr_wmask0", 32'(ram_wmask0), 32'hF);
    check("wr_grant", 32'(grant_o), 32'd1);
    check("wr_busy", 32'(busy_o), 32'd1);
    check("wr_ack_early", 32'(a_ack), 32'd0);
    @(posedge clk); #1;
    check("wr_csb0_release", 32'(ram_csb0), 32'd1);
    check("wr_ack", 32'(a_ack), 32'd1);
    drop_a();

    // B read of the same word
    round(0, 1, 0, 0, 8'h00, 8'h04, 32'd0, 32'd0, 4'h0, 4'hF);

    // Simultaneous requests: strict alternation
    for (int i = 0; i < 6; i++)
      round(1, 1, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            $urandom, $urandom, 4'($urandom), 4'($urandom));

    // Random mixture of single and dual requests
    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      round(pat[0], pat[1], 1'($urandom), 1'($urandom), 8'($urandom_range(0, 31)),
            8'($urandom_range(0, 31)), $urandom, $urandom, 4'($urandom), 4'($urandom));
    end

    // B aborts its read during WAIT
    @(posedge clk); #1;
    held = b_dout;
    b_stb = 1; b_cyc = 1; b_we = 0; b_adr = 10'h020; b_sel = 4'hF;
    last_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(busy_o), 32'd1);
    drop_b();
    @(posedge clk); #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ack", 32'(b_ack), 32'd0);
    check("abort_dat_b", b_dout, held);
    round(1, 0, 0, 0, 8'h08, 8'h00, 32'd0, 32'd0, 4'hF, 4'h0);

    // Reset asserted while a read is in WAIT
    @(posedge clk); #1;
    b_stb = 1; b_cyc = 1; b_we = 0; b_adr = 10'h030;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drop_b();
    #1;
    check("rstw_csb0", 32'(ram_csb0), 32'd1);
    check("rstw_ack", 32'({a_ack, b_ack}), 32'd0);
    check("rstw_grant", 32'(grant_o), 32'd0);
    check("rstw_busy", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rstw_no_ack", 32'({a_ack, b_ack}), 32'd0);
    round(1, 1, 0, 1, 8'h0C, 8'h0C, 32'd0, 32'h12345678, 4'h0, 4'h3);
    round(1, 1, 0, 0, 8'h0C, 8'h0C, 32'd0, 32'd0, 4'h0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
